// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with one byte-masked write port and
// two registered read ports sharing a read enable.
// After reset (or on a clr request) a sequencer zeroes every entry, one per
// cycle, while busy is high; reads and writes are only accepted when idle.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a read that hits
// the address written in the same cycle returns the byte-merged new value;
// when undefined it returns the pre-write contents.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr_a,
    input  logic [ADDR_W-1:0]     raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    // Storage is never reset; the clear sequencer zeroes it instead.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;
    logic                rvalid_q;

    logic                ready;
    logic                rd_acc;
    logic                wr_acc;
    logic                raddr_a_zero, raddr_b_zero;

    assign ready  = (state_q == S_READY);
    assign rd_acc = ready && !sel_n && re;
    // A write in the same cycle as clr is dropped; address 0 is read-only
    // when it is the hardwired zero entry.
    assign wr_acc = ready && !sel_n && we && !clr &&
                    !((ZERO_REG != 0) && (waddr == '0));

    assign raddr_a_zero = (ZERO_REG != 0) && (raddr_a == '0);
    assign raddr_b_zero = (ZERO_REG != 0) && (raddr_b == '0);

    // Sequencer state and clear counter; reset forces a fresh clear pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: CLEAR walks 0..DEPTH-1 then goes READY; clr (re)starts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_READY: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Single storage write port, shared between the clearer and user writes.
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NB-1:0]       mem_be;

    // Select who owns the write port this cycle.
    always_comb begin
        mem_we    = wr_acc;
        mem_addr  = waddr;
        mem_wdata = wdata;
        mem_be    = wstrb;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end
    end

    // Byte-masked storage update.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic [DATA_W-1:0] rd_a_d, rd_b_d;

    assign old_a = mem_q[raddr_a];
    assign old_b = mem_q[raddr_b];

`ifdef REGFILE_BYPASS_EN
    logic [DATA_W-1:0] merged_a, merged_b;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign merged_a[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : old_a[gi*8 +: 8];
            assign merged_b[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : old_b[gi*8 +: 8];
        end
    endgenerate

    assign fwd_a = (wr_acc && (waddr == raddr_a)) ? merged_a : old_a;
    assign fwd_b = (wr_acc && (waddr == raddr_b)) ? merged_b : old_b;
`else
    assign fwd_a = old_a;
    assign fwd_b = old_b;
`endif

    assign rd_a_d = raddr_a_zero ? '0 : fwd_a;
    assign rd_b_d = raddr_b_zero ? '0 : fwd_b;

    // Registered read data and one-cycle valid; data holds when no read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_a_q <= rd_a_d;
                rdata_b_q <= rd_b_d;
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign rvalid  = rvalid_q;
    assign busy    = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of the register file.
module tb_regfile_mp;

    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_n, clr, we, re;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata_a, rdata_b;
    logic        rvalid, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          clear_left;
    logic [31:0] last_a, last_b;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_n   (sel_n),
        .clr     (clr),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .rvalid  (rvalid),
        .busy    (busy)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit wacc);
        if (ra == 5'd0) return 32'h0;
        if (BYP && wacc && ra == waddr) return merge(model_mem[ra], wdata, wstrb);
        return model_mem[ra];
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // One clock edge: the model consumes the inputs present at the edge.
    task automatic step();
        bit   rdy, racc, wacc;
        exp_t e;
        @(posedge clk);
        rdy  = (clear_left == 0);
        racc = rdy && !sel_n && re;
        wacc = rdy && !sel_n && we && !clr && (waddr != 5'd0);
        if (racc) begin
            e.a = exp_rd(raddr_a, wacc);
            e.b = exp_rd(raddr_b, wacc);
            exp_q.push_back(e);
            $display("READ  a[%0d] b[%0d] expect %h %h", raddr_a, raddr_b, e.a, e.b);
        end
        if (wacc) begin
            model_mem[waddr] = merge(model_mem[waddr], wdata, wstrb);
            $display("WRITE [%0d] data %h strb %b", waddr, wdata, wstrb);
        end
        if (clr) begin
            clear_left = DEPTH;
            zero_model();
        end else if (clear_left > 0) begin
            clear_left--;
        end
        #1;
    endtask

    task automatic drive(input bit s, input bit c, input bit w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [3:0] ws, input bit r,
                         input logic [4:0] ra, input logic [4:0] rb);
        sel_n = s; clr = c; we = w; waddr = wa; wdata = wd; wstrb = ws;
        re = r; raddr_a = ra; raddr_b = rb;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sel_n = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rvalid !== 1'b0 || rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rvalid=%b a=%h b=%h, expected 1 0 0 0",
                     busy, rvalid, rdata_a, rdata_b);
        end
        exp_q.delete();
        last_a = 32'h0;
        last_b = 32'h0;
        clear_left = DEPTH;
        zero_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("RESET released");
    endtask

    // Monitor: busy tracks the model; each rvalid pops one expectation;
    // without rvalid the read data must hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1 || rst_n === 1'b0) begin
            checks++;
            if (busy !== (clear_left > 0)) begin
                errors++;
                $display("FAIL busy: got %b expected %b", busy, (clear_left > 0));
            end
            if (rvalid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_spurious: got rvalid=1 expected 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rdata_a !== e.a || rdata_b !== e.b) begin
                        errors++;
                        $display("FAIL rdata: got %h %h expected %h %h", rdata_a, rdata_b, e.a, e.b);
                    end
                    last_a = e.a;
                    last_b = e.b;
                end
            end else begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL rvalid_missing: got rvalid=%b expected 1", rvalid);
                    void'(exp_q.pop_front());
                end else if (rdata_a !== last_a || rdata_b !== last_b) begin
                    errors++;
                    $display("FAIL rdata_hold: got %h %h expected %h %h", rdata_a, rdata_b, last_a, last_b);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        sel_n = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        waddr = 0; wdata = 0; wstrb = 0; raddr_a = 0; raddr_b = 0;
        clear_left = DEPTH;
        last_a = 0; last_b = 0;
        zero_model();
        #1;
        do_reset();

        // Clear pass after release, then every entry reads zero.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 0, 0, 1, 5'(i), 5'(DEPTH - 1 - i));

        // Byte-masked write.
        drive(0, 0, 1, 5, 32'hDEADBEEF, 4'b1111, 0, 0, 0);
        drive(0, 0, 1, 5, 32'h000000AA, 4'b0001, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5);
        idle(2);

        // Same-cycle write and read of the same address.
        drive(0, 0, 1, 3, 32'h11111111, 4'b1111, 0, 0, 0);
        drive(0, 0, 1, 3, 32'h12345678, 4'b1111, 1, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 5);
        drive(0, 0, 1, 6, 32'hA5A5A5A5, 4'b0110, 1, 6, 3);

        // Hardwired zero entry.
        drive(0, 0, 1, 0, 32'hFFFFFFFF, 4'b1111, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Deselected: nothing changes, data holds.
        drive(1, 0, 1, 9, 32'hCAFEF00D, 4'b1111, 1, 5, 3);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 9, 5);

        // Write with clr is dropped; clr restarted mid-clear.
        drive(0, 0, 1, 7, 32'h00000055, 4'b1111, 0, 0, 0);
        drive(0, 1, 1, 8, 32'h77777777, 4'b1111, 0, 0, 0);
        idle(5);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(DEPTH);
        drive(0, 0, 0, 0, 0, 0, 1, 7, 8);

        // Reset during a clear pass.
        drive(0, 0, 1, 7, 32'h00000055, 4'b1111, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        do_reset();
        idle(DEPTH);
        drive(0, 0, 0, 0, 0, 0, 1, 7, 7);

        // Reset during a read: no rvalid may follow.
        drive(0, 0, 1, 12, 32'h89ABCDEF, 4'b1111, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 12, 12);
        do_reset();
        idle(DEPTH);

        // Randomized traffic focused on a few addresses to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, 1'($urandom),
                  5'($urandom_range(0, 7)), $urandom, 4'($urandom), 1'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired zero.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 sel_n  in  1  chip select, active low; when 1, reads and writes are ignored.
REQ-007 clr  in  1  synchronous request to re-zero all entries.
REQ-008 we  in  1  write enable.
REQ-009 waddr  in  ADDR_W  write address.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 wstrb  in  DATA_W/8  byte enables for the write.
REQ-012 re  in  1  read enable, both read ports.
REQ-013 raddr_a, raddr_b  in  ADDR_W each  read addresses.
REQ-014 rdata_a, rdata_b  out  DATA_W each  registered read data.
REQ-015 rvalid  out  1  one-cycle pulse: rdata_a/rdata_b updated this cycle.
REQ-016 busy  out  1  high while the clear sequencer runs.

Function
REQ-017 FSM SHALL have two states: CLEAR and READY.
REQ-018 In CLEAR, a counter SHALL zero one entry per cycle, addresses 0 to DEPTH-1, then move to READY; busy=1 throughout; CLEAR lasts exactly DEPTH cycles.
REQ-019 In READY, clr=1 SHALL enter CLEAR with counter 0 on the next edge; clr during CLEAR SHALL restart the counter at 0.
REQ-020 While busy=1, we and re SHALL be ignored and rvalid SHALL stay 0.
REQ-021 Write: when READY, sel_n=0, we=1, each byte i of entry waddr with wstrb[i]=1 SHALL take wdata byte i at the edge; other bytes unchanged.
REQ-022 Read: when READY, sel_n=0, re=1, rdata_a/rdata_b SHALL load entry raddr_a/raddr_b at the edge and rvalid SHALL be 1 for the following cycle only; latency 1 cycle.
REQ-023 When no read is accepted, rdata_a/rdata_b SHALL hold their last value; outputs SHALL never be high-impedance.
REQ-024 raddr_a == raddr_b SHALL return identical data on both ports.
REQ-025 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including the bypass case.
REQ-026 Same-cycle write and read of the same address SHALL follow REQ-035/REQ-036.
REQ-027 A write and a clr in the same READY cycle: the write SHALL be dropped.

Reset
REQ-028 rst_n=0 SHALL immediately force state CLEAR, counter 0, busy=1, rvalid=0, rdata_a=0, rdata_b=0.
REQ-029 Entries are not reset asynchronously; they are zeroed by the CLEAR sequence after rst_n rises.
REQ-030 rst_n asserted mid-CLEAR or mid-read SHALL abort the operation and apply REQ-028; no partial rvalid.
REQ-031 After rst_n rises, the first write or read SHALL be accepted exactly DEPTH cycles later.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-033 Forwarding applies only when a write and a read of the same address are accepted in the same cycle.
REQ-034 The effect on the read result is given in REQ-035 (macro defined) and REQ-036 (macro undefined).
REQ-035 REGFILE_BYPASS_EN defined: that read SHALL return the merged value: new bytes where wstrb=1, old bytes elsewhere.
REQ-036 REGFILE_BYPASS_EN undefined: that read SHALL return the pre-write value; the new value is visible from the next read.

Verification
REQ-037 Release rst_n, DEPTH=32 -> busy=1 for exactly 32 cycles; a read of every address then returns 0x00000000.
REQ-038 Write 0xDEADBEEF to addr 5 with wstrb=4'b1111, then wstrb=4'b0001 with data 0x000000AA -> read addr 5 returns 0xDEADBEAA one cycle later, rvalid pulses once.
REQ-039 Same-cycle write 0x12345678 to addr 3 and read addr 3, where addr 3 held 0x11111111 -> 0x12345678 with REGFILE_BYPASS_EN, 0x11111111 without.
REQ-040 Write 0xFFFFFFFF to addr 0 with ZERO_REG=1 -> read addr 0 returns 0x00000000 on both ports.
REQ-041 sel_n=1 with we=1 and re=1 -> no entry changes, rvalid=0, rdata holds its prior value.
REQ-042 Write addr 7 = 0x55, then pulse clr, then assert rst_n=0 at cycle 10 of CLEAR -> outputs zero at once; a full 32-cycle CLEAR follows release; addr 7 reads 0.
